// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit/change engine.
// Coin units, FSM state type and the greedy change-coin selector.
package vend_pkg;

    localparam int unsigned QUARTER_UNITS = 1;
    localparam int unsigned DOLLAR_UNITS  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } vend_state_e;

    // Largest coin that does not overshoot the remaining change.
    function automatic logic greedy_dollar(input int unsigned remaining);
        return remaining >= DOLLAR_UNITS;
    endfunction

    // Value in quarter units of one dispensed change coin.
    function automatic int unsigned coin_units(input logic is_dollar);
        return is_dollar ? DOLLAR_UNITS : QUARTER_UNITS;
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Change dispenser: holds the remaining change and runs the
// valid/ready coin handshake, one greedy coin per accepted beat.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] load_val_i,
    input  logic                coin_ready_i,
    output logic                coin_valid_o,
    output logic                coin_dollar_o,
    output logic [CREDIT_W-1:0] remain_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] remain_q;
    logic [CREDIT_W-1:0] remain_d;
    logic [CREDIT_W-1:0] step;
    logic                valid_q;
    logic                dollar_q;

    // Remaining change after the current coin leaves; done on the last one.
    always_comb begin
        step     = CREDIT_W'(coin_units(dollar_q));
        remain_d = remain_q - step;
        done_o   = valid_q && coin_ready_i && (remain_d == '0);
    end

    // Coin type only moves on an accepted beat, so it is stable under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            remain_q <= '0;
            valid_q  <= 1'b0;
            dollar_q <= 1'b0;
        end else if (load_i) begin
            remain_q <= load_val_i;
            valid_q  <= 1'b1;
            dollar_q <= greedy_dollar(32'(load_val_i));
        end else if (valid_q && coin_ready_i) begin
            remain_q <= remain_d;
            valid_q  <= (remain_d != '0);
            dollar_q <= greedy_dollar(32'(remain_d));
        end
    end

    assign coin_valid_o  = valid_q;
    assign coin_dollar_o = dollar_q;
    assign remain_o      = remain_q;

endmodule

// File: rtl/vend_change_engine.sv
// Credit, vend and change engine: coin intake, price check, vend pulse.
// Optional refund path enabled by defining VEND_REFUND_EN.
module vend_change_engine
    import vend_pkg::*;
#(
    parameter  int NUM_SEL    = 4,
    parameter  int CREDIT_W   = 6,
    parameter  int MAX_CREDIT = 20,
    localparam int SEL_W      = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        quarter_in,
    input  logic                        dollar_in,
    input  logic                        sel_valid,
    input  logic [SEL_W-1:0]            sel_idx,
    input  logic [NUM_SEL*CREDIT_W-1:0] price,
    input  logic                        refund,
    input  logic                        coin_out_ready,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        busy,
    output logic                        vend_valid,
    output logic [SEL_W-1:0]            vend_idx,
    output logic                        deny,
    output logic                        coin_reject,
    output logic                        coin_out_valid,
    output logic                        coin_out_dollar
);

    localparam int SUM_W = CREDIT_W + 1;

    vend_state_e         state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                vend_valid_q;
    logic [SEL_W-1:0]    vend_idx_q;
    logic                deny_q;
    logic                coin_reject_q;

    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic                coin_any;
    logic                fits;
    logic [CREDIT_W-1:0] credit_acc;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_oor;
    logic                afford;
    logic [CREDIT_W-1:0] change_val;
    logic                refund_go;
    logic                load;
    logic [CREDIT_W-1:0] load_val;

    logic                disp_done;
    logic [CREDIT_W-1:0] disp_remain;

    // Index range check only exists when the index can exceed NUM_SEL-1.
    if ((1 << SEL_W) > NUM_SEL) begin : g_oor
        assign sel_oor = 32'(sel_idx) >= 32'(NUM_SEL);
    end else begin : g_no_oor
        assign sel_oor = 1'b0;
    end

`ifdef VEND_REFUND_EN
    assign refund_go = refund && (credit_q != '0);
`else
    logic unused_refund;
    assign unused_refund = refund;
    assign refund_go     = 1'b0;
`endif

    // Price lookup by compare so an out-of-range index never slices past.
    always_comb begin
        sel_price = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            if (sel_idx == SEL_W'(k)) begin
                sel_price = price[k*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Coin acceptance and vend/refund decision against registered credit.
    always_comb begin
        coin_any   = quarter_in || dollar_in;
        coin_val   = (quarter_in ? SUM_W'(QUARTER_UNITS) : '0)
                   + (dollar_in  ? SUM_W'(DOLLAR_UNITS)  : '0);
        sum        = {1'b0, credit_q} + coin_val;
        fits       = sum <= SUM_W'(MAX_CREDIT);
        credit_acc = fits ? sum[CREDIT_W-1:0] : credit_q;
        afford     = !sel_oor && (sel_price <= credit_q);
        change_val = credit_acc - sel_price;
        load       = 1'b0;
        load_val   = '0;
        if (state_q == IDLE) begin
            if (sel_valid) begin
                load     = afford && (change_val != '0);
                load_val = change_val;
            end else begin
                load     = refund_go;
                load_val = credit_acc;
            end
        end
    end

    // Main FSM with registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            vend_valid_q  <= 1'b0;
            vend_idx_q    <= '0;
            deny_q        <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            vend_valid_q  <= 1'b0;
            deny_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    coin_reject_q <= coin_any && !fits;
                    if (sel_valid && !afford) begin
                        deny_q   <= 1'b1;
                        credit_q <= credit_acc;
                    end else if (sel_valid) begin
                        vend_valid_q <= 1'b1;
                        vend_idx_q   <= sel_idx;
                        credit_q     <= '0;
                        if (load) state_q <= CHANGE;
                    end else if (load) begin
                        credit_q <= '0;
                        state_q  <= CHANGE;
                    end else begin
                        credit_q <= credit_acc;
                    end
                end
                CHANGE: begin
                    coin_reject_q <= coin_any;
                    deny_q        <= sel_valid;
                    if (disp_done) state_q <= IDLE;
                end
            endcase
        end
    end

    vend_change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_disp (
        .clk           (clk),
        .reset         (reset),
        .load_i        (load),
        .load_val_i    (load_val),
        .coin_ready_i  (coin_out_ready),
        .coin_valid_o  (coin_out_valid),
        .coin_dollar_o (coin_out_dollar),
        .remain_o      (disp_remain),
        .done_o        (disp_done)
    );

    assign busy        = (state_q == CHANGE);
    assign credit      = busy ? disp_remain : credit_q;
    assign vend_valid  = vend_valid_q;
    assign vend_idx    = vend_idx_q;
    assign deny        = deny_q;
    assign coin_reject = coin_reject_q;

endmodule
